// File: rtl/decode38_player_if.sv
// Bus between the encoder side and the decode38 player: code push strobe, player
// controls, and the LED/FIFO status returned to the board top.
interface decode38_player_if #(
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [2:0]    code;
    logic          code_valid;
    logic          en;
    logic          clr_ovf;
    logic [7:0]    y;
    logic          busy;
    logic          empty;
    logic          full;
    logic [LW-1:0] level;
    logic          overflow;

    modport master (
        output code, code_valid, en, clr_ovf,
        input  y, busy, empty, full, level, overflow
    );

    modport slave (
        input  code, code_valid, en, clr_ovf,
        output y, busy, empty, full, level, overflow
    );
endinterface

// File: rtl/decode38_player.sv
// 3-to-8 decoder/player: queues incoming 3-bit codes in a small FIFO and shows each
// one on the LEDs as a one-hot pattern for HOLD_CYCLES, with a one-cycle blank after.
module decode38_player #(
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 8
) (
    input logic              clk,
    input logic              rst,
    decode38_player_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, SHOW, GAP} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    cur_q, cur_d;
    logic [7:0]    y_q, y_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          ovf_q, ovf_d;
    logic [2:0]    mem_q [DEPTH];

    logic full, empty, push, pop;

    // full is the pre-edge value, so a pop in the same cycle never admits a push.
    always_comb begin
        full  = (level_q == LW'(DEPTH));
        empty = (level_q == '0);
        push  = bus.code_valid && !full;
        pop   = (state_q == IDLE) && bus.en && !empty;

        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        // A dropped push outranks a simultaneous clear.
        if (bus.code_valid && full) ovf_d = 1'b1;
        else if (bus.clr_ovf)       ovf_d = 1'b0;
        else                        ovf_d = ovf_q;
    end

    // y_d is the pattern for the next cycle, so y stays registered yet lines up with state.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        cur_d   = cur_q;
        y_d     = 8'h00;

        unique case (state_q)
            IDLE: begin
                if (pop) begin
                    cur_d   = mem_q[rd_ptr_q];
                    cnt_d   = CW'(HOLD_CYCLES - 1);
                    state_d = SHOW;
                    y_d     = 8'h01 << mem_q[rd_ptr_q];
                end
            end
            SHOW: begin
                if (bus.en) begin
                    if (cnt_q == '0) begin
                        state_d = GAP;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                        y_d   = 8'h01 << cur_q;
                    end
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            cur_q    <= '0;
            y_q      <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cur_q    <= cur_d;
            y_q      <= y_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    // NOTE: storage is not reset; level and pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.code;
    end

    assign bus.y        = y_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.empty    = empty;
    assign bus.full     = full;
    assign bus.level    = level_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_decode38_player.sv
// Directed bench for decode38_player (DEPTH=4, HOLD_CYCLES=8); cycle 0 is the first
// cycle after reset is released, and outputs are sampled 1 ns after each rising edge.
module tb_decode38_player;
    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;

    decode38_player_if #(.DEPTH(4)) bus ();

    decode38_player #(.DEPTH(4), .HOLD_CYCLES(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        bus.code       = 3'd0;
        bus.code_valid = 1'b0;
        bus.en         = 1'b0;
        bus.clr_ovf    = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({bus.y, bus.busy, bus.empty, bus.full, bus.level, bus.overflow} !==
            {8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_state: got y=%h busy=%b empty=%b full=%b level=%0d ovf=%b, expected y=00 busy=0 empty=1 full=0 level=0 ovf=0",
                     bus.y, bus.busy, bus.empty, bus.full, bus.level, bus.overflow);
        end
    endtask

    task automatic test_single();
        logic [7:0] ey;
        logic       eb;
        do_reset();
        bus.en = 1'b1; bus.code = 3'd5; bus.code_valid = 1'b1;
        step();
        bus.code_valid = 1'b0;
        vectors++;
        if ({bus.empty, bus.level, bus.y} !== {1'b0, 3'd1, 8'h00}) begin
            miscompares++;
            $display("FAIL single_c1: got empty=%b level=%0d y=%h, expected empty=0 level=1 y=00",
                     bus.empty, bus.level, bus.y);
        end
        for (int c = 2; c <= 11; c++) begin
            step();
            ey = (c <= 9) ? 8'h20 : 8'h00;
            eb = (c <= 10);
            vectors++;
            if ({bus.y, bus.busy} !== {ey, eb}) begin
                miscompares++;
                $display("FAIL single_c%0d: got y=%h busy=%b, expected y=%h busy=%b", c, bus.y, bus.busy, ey, eb);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] codes [3];
        logic [7:0] ey;
        codes[0] = 3'd0; codes[1] = 3'd7; codes[2] = 3'd3;
        do_reset();
        bus.en = 1'b1;
        bus.code = codes[0]; bus.code_valid = 1'b1;
        step();
        bus.code = codes[1];
        vectors++;
        if (bus.level !== 3'd1) begin
            miscompares++;
            $display("FAIL b2b_level_c1: got %0d, expected 1", bus.level);
        end
        step();
        bus.code = codes[2];
        vectors++;
        if ({bus.level, bus.y} !== {3'd1, 8'h01}) begin
            miscompares++;
            $display("FAIL b2b_c2: got level=%0d y=%h, expected level=1 y=01", bus.level, bus.y);
        end
        step();
        bus.code_valid = 1'b0;
        vectors++;
        if (bus.level !== 3'd2) begin
            miscompares++;
            $display("FAIL b2b_level_c3: got %0d, expected 2", bus.level);
        end
        for (int c = 3; c <= 31; c++) begin
            ey = 8'h00;
            for (int i = 0; i < 3; i++)
                if (c >= 2 + 10 * i && c <= 9 + 10 * i) ey = 8'h01 << codes[i];
            vectors++;
            if (bus.y !== ey) begin
                miscompares++;
                $display("FAIL b2b_y_c%0d: got %h, expected %h", c, bus.y, ey);
            end
            if (c == 12) begin
                vectors++;
                if (bus.level !== 3'd1) begin
                    miscompares++;
                    $display("FAIL b2b_level_c12: got %0d, expected 1", bus.level);
                end
            end
            if (c == 31) begin
                vectors++;
                if ({bus.empty, bus.level, bus.busy} !== {1'b1, 3'd0, 1'b0}) begin
                    miscompares++;
                    $display("FAIL b2b_drained: got empty=%b level=%0d busy=%b, expected empty=1 level=0 busy=0",
                             bus.empty, bus.level, bus.busy);
                end
            end
            step();
        end
    endtask

    task automatic test_overflow();
        logic [2:0] codes [5];
        logic [7:0] ey;
        codes[0] = 3'd1; codes[1] = 3'd2; codes[2] = 3'd3; codes[3] = 3'd4; codes[4] = 3'd6;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            bus.code = codes[i]; bus.code_valid = 1'b1;
            if (i == 4) begin
                vectors++;
                if ({bus.full, bus.level, bus.overflow} !== {1'b1, 3'd4, 1'b0}) begin
                    miscompares++;
                    $display("FAIL ovf_full: got full=%b level=%0d ovf=%b, expected full=1 level=4 ovf=0",
                             bus.full, bus.level, bus.overflow);
                end
            end
            step();
        end
        // cycle 5: dropped push visible; retry a push together with clr_ovf (set wins)
        vectors++;
        if ({bus.overflow, bus.level, bus.full, bus.y, bus.busy} !== {1'b1, 3'd4, 1'b1, 8'h00, 1'b0}) begin
            miscompares++;
            $display("FAIL ovf_set: got ovf=%b level=%0d full=%b y=%h busy=%b, expected ovf=1 level=4 full=1 y=00 busy=0",
                     bus.overflow, bus.level, bus.full, bus.y, bus.busy);
        end
        bus.code = 3'd5; bus.clr_ovf = 1'b1;
        step();
        bus.code_valid = 1'b0;
        vectors++;
        if ({bus.overflow, bus.level} !== {1'b1, 3'd4}) begin
            miscompares++;
            $display("FAIL ovf_set_wins: got ovf=%b level=%0d, expected ovf=1 level=4", bus.overflow, bus.level);
        end
        step();
        bus.clr_ovf = 1'b0;
        vectors++;
        if (bus.overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_clear: got %b, expected 0", bus.overflow);
        end
        bus.en = 1'b1;
        step();
        for (int c = 8; c <= 47; c++) begin
            ey = 8'h00;
            for (int i = 0; i < 4; i++)
                if (c >= 8 + 10 * i && c <= 15 + 10 * i) ey = 8'h01 << codes[i];
            vectors++;
            if (bus.y !== ey) begin
                miscompares++;
                $display("FAIL ovf_play_c%0d: got y=%h, expected %h", c, bus.y, ey);
            end
            if (c == 47) begin
                vectors++;
                if ({bus.empty, bus.busy} !== {1'b1, 1'b0}) begin
                    miscompares++;
                    $display("FAIL ovf_drained: got empty=%b busy=%b, expected empty=1 busy=0", bus.empty, bus.busy);
                end
            end
            step();
        end
    endtask

    task automatic test_pause();
        logic [7:0] ey;
        logic       eb;
        do_reset();
        bus.en = 1'b1; bus.code = 3'd2; bus.code_valid = 1'b1;
        step();
        bus.code_valid = 1'b0;
        step();
        for (int c = 2; c <= 14; c++) begin
            ey = ((c >= 2 && c <= 4) || (c >= 8 && c <= 12)) ? 8'h04 : 8'h00;
            eb = (c <= 13);
            vectors++;
            if ({bus.y, bus.busy} !== {ey, eb}) begin
                miscompares++;
                $display("FAIL pause_c%0d: got y=%h busy=%b, expected y=%h busy=%b", c, bus.y, bus.busy, ey, eb);
            end
            if (c == 4) bus.en = 1'b0;
            if (c == 7) bus.en = 1'b1;
            step();
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] ey;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus.code = 3'(i + 1); bus.code_valid = 1'b1;
            step();
        end
        vectors++;
        if ({bus.full, bus.level} !== {1'b1, 3'd4}) begin
            miscompares++;
            $display("FAIL fpp_full: got full=%b level=%0d, expected full=1 level=4", bus.full, bus.level);
        end
        bus.en = 1'b1; bus.code = 3'd5;
        step();
        bus.code_valid = 1'b0;
        vectors++;
        if ({bus.level, bus.overflow, bus.full} !== {3'd3, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL fpp_drop: got level=%0d ovf=%b full=%b, expected level=3 ovf=1 full=0",
                     bus.level, bus.overflow, bus.full);
        end
        for (int c = 5; c <= 45; c++) begin
            ey = 8'h00;
            for (int i = 0; i < 4; i++)
                if (c >= 5 + 10 * i && c <= 12 + 10 * i) ey = 8'h01 << (i + 1);
            vectors++;
            if (bus.y !== ey) begin
                miscompares++;
                $display("FAIL fpp_play_c%0d: got y=%h, expected %h", c, bus.y, ey);
            end
            step();
        end
        vectors++;
        if ({bus.empty, bus.busy} !== {1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL fpp_drained: got empty=%b busy=%b, expected empty=1 busy=0", bus.empty, bus.busy);
        end
    endtask

    task automatic test_reset_mid_show();
        do_reset();
        bus.en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.code = 3'(i + 1); bus.code_valid = 1'b1;
            step();
        end
        bus.code_valid = 1'b0;
        vectors++;
        if ({bus.level, bus.y} !== {3'd2, 8'h02}) begin
            miscompares++;
            $display("FAIL rms_pre: got level=%0d y=%h, expected level=2 y=02", bus.level, bus.y);
        end
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        vectors++;
        if ({bus.y, bus.busy, bus.empty, bus.level, bus.full} !== {8'h00, 1'b0, 1'b1, 3'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL rms_post: got y=%h busy=%b empty=%b level=%0d full=%b, expected y=00 busy=0 empty=1 level=0 full=0",
                     bus.y, bus.busy, bus.empty, bus.level, bus.full);
        end
        for (int c = 0; c < 25; c++) begin
            step();
            vectors++;
            if ({bus.y, bus.busy} !== {8'h00, 1'b0}) begin
                miscompares++;
                $display("FAIL rms_replay_%0d: got y=%h busy=%b, expected y=00 busy=0", c, bus.y, bus.busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_pause();
        test_full_push_pop();
        test_reset_mid_show();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
